game_flow_ctrl: RTL
===================

Name: game_flow_ctrl

Overview:
- Sequences one play session of the game datapath: menu idle → countdown → play → result → idle.
- Drives the datapath's game-enable level and conditions raw joystick state into one-cycle move/press pulses, with auto-repeat while a direction is held.
- Reports the current scene and elapsed play time so the display mux and score overlay can select sources.
- Sits between the joystick/menu logic and the game datapath top.

Parameters:
- TICK_DIV, 100000000: clk cycles per 1 s tick; must be ≥2.
- COUNTDOWN_S, 3: countdown length in seconds; 0 goes straight to play.
- REPEAT_DLY, 40000000: cycles a direction is held before the first repeat pulse.
- REPEAT_RATE, 10000000: cycles between subsequent repeat pulses.
- RESULT_HOLD_S, 5: seconds the result scene is held before auto-return to idle.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- start_req  in  1  level from the menu; its rising edge starts a session.
- abort_req  in  1  level; when high, abandons a session in countdown or play.
- jstk_pos_raw  in  4  {up,down,left,right}; synchronous to clk.
- jstk_press_raw  in  1  joystick button; synchronous to clk.
- finish_game  in  1  level from the game datapath; high means the game is over.
- game_en  out  1  enable level to the game datapath.
- jstk_pos  out  4  one-cycle move pulses to the datapath; one-hot or zero.
- jstk_press  out  1  one-cycle press pulse.
- scene  out  2  0=IDLE, 1=COUNTDOWN, 2=PLAY, 3=RESULT.
- countdown  out  4  seconds remaining; nonzero only in COUNTDOWN.
- elapsed_s  out  10  whole seconds of play, saturating at 999.

Behaviour:
- Reset (rst=0, async): scene=IDLE; all outputs 0; all counters and edge registers 0.
- All outputs are registered.
- Edge detect: start_req, jstk_press_raw and jstk_pos_raw are registered once. A rising edge is raw=1 & prev=0, evaluated at clock edge N; the resulting pulse or state change is visible after edge N.
- Tick counter:
  - Counts 0..TICK_DIV-1 and produces sec_tick when it wraps.
  - Cleared on every scene change, so the first tick in a scene arrives TICK_DIV cycles after entry.
- IDLE:
  - game_en=0.
  - start_req rising edge → COUNTDOWN with countdown=COUNTDOWN_S, or → PLAY if COUNTDOWN_S=0.
  - A start_req held high through reset does not start a session; an edge is required.
- COUNTDOWN:
  - countdown decrements on each sec_tick.
  - When a sec_tick arrives with countdown=1 → PLAY and countdown=0.
  - abort_req → IDLE.
- PLAY:
  - game_en=1 for the whole scene.
  - elapsed_s cleared on entry, +1 per sec_tick, saturates at 999.
  - finish_game=1 → RESULT; game_en is 0 from the next cycle.
  - abort_req alone → IDLE.
  - finish_game and abort_req in the same cycle → RESULT (finish wins).
- RESULT:
  - game_en=0; elapsed_s frozen.
  - Returns to IDLE after RESULT_HOLD_S sec_ticks, or on a jstk_press_raw rising edge, whichever comes first.
  - elapsed_s is cleared on the return to IDLE.
- start_req is ignored outside IDLE; abort_req is ignored in IDLE and RESULT.
- Joystick conditioning (active only in PLAY; outputs forced 0 elsewhere):
  - A raw value with more than one bit set counts as zero (no direction).
  - When the raw value changes to a valid one-hot value, that bit pulses for 1 cycle.
  - While the same one-hot value is held: the next pulse comes REPEAT_DLY cycles after the first, then one every REPEAT_RATE cycles.
  - A value change, or entering PLAY, restarts the repeat timer. A direction already held on entry to PLAY counts as a new value and pulses on the first PLAY cycle.
  - jstk_press pulses on a rising edge only; it never repeats.
  - A press edge in RESULT is consumed by the scene exit and is not forwarded.
- Repeat counter width is $clog2 of max(REPEAT_DLY, REPEAT_RATE)+1.
- Tick counter width is $clog2(TICK_DIV).
- Reset asserted mid-session: game_en drops asynchronously and scene returns to IDLE.

Test Plan:
All scenarios use TICK_DIV=10, COUNTDOWN_S=3, REPEAT_DLY=20, REPEAT_RATE=5, RESULT_HOLD_S=2.
1. Release reset, pulse start_req → scene=1 with countdown 3,2,1 at 10-cycle steps; scene=2 and game_en=1 exactly 30 cycles after start.
2. In PLAY, hold jstk_pos_raw=4'b0010 for 40 cycles → jstk_pos=4'b0010 pulses at relative cycles 0, 20, 25, 30, 35; raw 4'b0011 → no pulses.
3. In PLAY, wait 55 cycles, then assert finish_game → elapsed_s=5; scene=3 and game_en=0 next cycle; scene=0 20 cycles later.
4. In RESULT, give a press edge → scene=0 next cycle; jstk_press stays 0 throughout.
5. In PLAY, assert abort_req and finish_game in the same cycle → scene=3; a separate abort in COUNTDOWN → scene=0, game_en never rises.
6. Pull rst low mid-PLAY with jstk_pos_raw held → all outputs 0 immediately; after release with start_req still high, scene stays 0 until a new start_req rising edge.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Session sequencer for the game datapath: idle -> countdown -> play -> result.
// Also conditions raw joystick state into single-cycle move/press pulses with auto-repeat.
module game_flow_ctrl #(
    parameter int TICK_DIV      = 100000000,
    parameter int COUNTDOWN_S   = 3,
    parameter int REPEAT_DLY    = 40000000,
    parameter int REPEAT_RATE   = 10000000,
    parameter int RESULT_HOLD_S = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_req,
    input  logic       abort_req,
    input  logic [3:0] jstk_pos_raw,
    input  logic       jstk_press_raw,
    input  logic       finish_game,
    output logic       game_en,
    output logic [3:0] jstk_pos,
    output logic       jstk_press,
    output logic [1:0] scene,
    output logic [3:0] countdown,
    output logic [9:0] elapsed_s
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_PLAY   = 2'd2,
        S_RESULT = 2'd3
    } scene_e;

    localparam int TW      = $clog2(TICK_DIV);
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam int HW      = (RESULT_HOLD_S > 1) ? $clog2(RESULT_HOLD_S) : 1;

    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] DLY_C       = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] RATE_C      = RW'(REPEAT_RATE);
    localparam logic [HW-1:0] HOLD_LAST   = HW'((RESULT_HOLD_S > 0) ? RESULT_HOLD_S - 1 : 0);
    localparam logic          HOLD_ZERO   = (RESULT_HOLD_S == 0) ? 1'b1 : 1'b0;
    localparam logic          CD_ZERO     = (COUNTDOWN_S == 0) ? 1'b1 : 1'b0;
    localparam logic [3:0]    CD_INIT     = 4'(COUNTDOWN_S);
    localparam logic [9:0]    ELAPSED_MAX = 10'd999;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    scene_e        scene_q,   scene_d;
    logic          start_prev_q, start_prev_d;
    logic          start_armed_q, start_armed_d;
    logic          press_prev_q, press_prev_d;
    logic [3:0]    pos_prev_q, pos_prev_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_first_q, rep_first_d;
    logic [HW-1:0] res_cnt_q, res_cnt_d;
    logic [3:0]    countdown_q, countdown_d;
    logic [9:0]    elapsed_q, elapsed_d;
    logic          game_en_q, game_en_d;
    logic [3:0]    jstk_pos_q, jstk_pos_d;
    logic          jstk_press_q, jstk_press_d;

    logic [3:0]    pos_valid_s;
    logic          start_edge_s;
    logic          press_edge_s;
    logic          sec_tick_s;
    logic          hold_done_s;
    logic          scene_chg_s;
    logic          new_dir_s;
    logic [RW-1:0] rep_inc_s;

    // Start only counts once start_req has been seen low after reset.
    assign pos_valid_s  = is_onehot4(jstk_pos_raw) ? jstk_pos_raw : 4'd0;
    assign start_edge_s = start_req & ~start_prev_q & start_armed_q;
    assign press_edge_s = jstk_press_raw & ~press_prev_q;
    assign sec_tick_s   = (tick_cnt_q == TICK_LAST);
    assign hold_done_s  = HOLD_ZERO | (sec_tick_s & (res_cnt_q == HOLD_LAST));
    assign scene_chg_s  = (scene_d != scene_q);
    assign rep_inc_s    = rep_cnt_q + RW'(1);
    assign new_dir_s    = (pos_valid_s != 4'd0) &&
                          ((pos_valid_s != pos_prev_q) || (scene_q != S_PLAY));

    // Scene transitions and countdown value.
    always_comb begin
        scene_d     = scene_q;
        countdown_d = countdown_q;
        case (scene_q)
            S_IDLE: begin
                if (start_edge_s) begin
                    if (CD_ZERO) begin
                        scene_d = S_PLAY;
                    end else begin
                        scene_d     = S_COUNT;
                        countdown_d = CD_INIT;
                    end
                end else begin
                    scene_d = S_IDLE;
                end
            end
            S_COUNT: begin
                if (abort_req) begin
                    scene_d     = S_IDLE;
                    countdown_d = 4'd0;
                end else if (sec_tick_s) begin
                    if (countdown_q <= 4'd1) begin
                        scene_d     = S_PLAY;
                        countdown_d = 4'd0;
                    end else begin
                        countdown_d = countdown_q - 4'd1;
                    end
                end else begin
                    scene_d = S_COUNT;
                end
            end
            S_PLAY: begin
                if (finish_game) begin
                    scene_d = S_RESULT;
                end else if (abort_req) begin
                    scene_d = S_IDLE;
                end else begin
                    scene_d = S_PLAY;
                end
            end
            S_RESULT: begin
                if (press_edge_s || hold_done_s) begin
                    scene_d = S_IDLE;
                end else begin
                    scene_d = S_RESULT;
                end
            end
            default: begin
                scene_d     = S_IDLE;
                countdown_d = 4'd0;
            end
        endcase
    end

    // Second tick, result hold and elapsed-time counters.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        res_cnt_d  = res_cnt_q;
        elapsed_d  = elapsed_q;
        game_en_d  = (scene_d == S_PLAY);
        if (scene_chg_s || sec_tick_s) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
        if (scene_chg_s) begin
            res_cnt_d = '0;
        end else if ((scene_q == S_RESULT) && sec_tick_s) begin
            res_cnt_d = res_cnt_q + HW'(1);
        end else begin
            res_cnt_d = res_cnt_q;
        end
        if ((scene_d == S_IDLE) || ((scene_d == S_PLAY) && (scene_q != S_PLAY))) begin
            elapsed_d = 10'd0;
        end else if ((scene_q == S_PLAY) && sec_tick_s && (elapsed_q != ELAPSED_MAX)) begin
            elapsed_d = elapsed_q + 10'd1;
        end else begin
            elapsed_d = elapsed_q;
        end
    end

    // Joystick pulse generation with first-delay / steady-rate auto-repeat.
    always_comb begin
        jstk_pos_d    = 4'd0;
        rep_cnt_d     = '0;
        rep_first_d   = 1'b1;
        pos_prev_d    = pos_valid_s;
        press_prev_d  = jstk_press_raw;
        start_prev_d  = start_req;
        start_armed_d = start_armed_q | ~start_req;
        jstk_press_d  = (scene_d == S_PLAY) & press_edge_s;
        if (scene_d != S_PLAY) begin
            jstk_pos_d = 4'd0;
        end else if (new_dir_s) begin
            jstk_pos_d = pos_valid_s;
        end else if (pos_valid_s == 4'd0) begin
            jstk_pos_d = 4'd0;
        end else if ((rep_first_q && (rep_inc_s == DLY_C)) ||
                     (!rep_first_q && (rep_inc_s == RATE_C))) begin
            jstk_pos_d  = pos_valid_s;
            rep_first_d = 1'b0;
        end else begin
            rep_cnt_d   = rep_inc_s;
            rep_first_d = rep_first_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scene_q       <= S_IDLE;
            start_prev_q  <= 1'b0;
            start_armed_q <= 1'b0;
            press_prev_q  <= 1'b0;
            pos_prev_q    <= 4'd0;
            tick_cnt_q    <= '0;
            rep_cnt_q     <= '0;
            rep_first_q   <= 1'b0;
            res_cnt_q     <= '0;
            countdown_q   <= 4'd0;
            elapsed_q     <= 10'd0;
            game_en_q     <= 1'b0;
            jstk_pos_q    <= 4'd0;
            jstk_press_q  <= 1'b0;
        end else begin
            scene_q       <= scene_d;
            start_prev_q  <= start_prev_d;
            start_armed_q <= start_armed_d;
            press_prev_q  <= press_prev_d;
            pos_prev_q    <= pos_prev_d;
            tick_cnt_q    <= tick_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            rep_first_q   <= rep_first_d;
            res_cnt_q     <= res_cnt_d;
            countdown_q   <= countdown_d;
            elapsed_q     <= elapsed_d;
            game_en_q     <= game_en_d;
            jstk_pos_q    <= jstk_pos_d;
            jstk_press_q  <= jstk_press_d;
        end
    end

    assign scene      = scene_q;
    assign countdown  = countdown_q;
    assign elapsed_s  = elapsed_q;
    assign game_en    = game_en_q;
    assign jstk_pos   = jstk_pos_q;
    assign jstk_press = jstk_press_q;

endmodule
